univ_shift_reg: RTL and testbench

//   Parametrised universal shift register, the successor to the fixed 4-bit serial-in shifter.

---
 rtl/shift_reg_pkg.sv | 17 +
 rtl/shift_reg_step.sv | 30 +++
 rtl/univ_shift_reg.sv | 106 ++++++++++
 tb/tb_univ_shift_reg.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared encodings for the universal shift register family: operation modes
// and burst-engine FSM states.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHL  = 3'd1;
  localparam logic [2:0] MODE_SHR  = 3'd2;
  localparam logic [2:0] MODE_ROL  = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_LOAD = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/shift_reg_step.sv
// Combinational next-value function for a STEP-bit shift/rotate/load of a
// WIDTH-bit register; shared by shift-based blocks.
import shift_reg_pkg::*;

module shift_reg_step #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic [STEP-1:0]  s_in_l,
  input  logic [STEP-1:0]  s_in_r,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_SHL:  q_next = {q[WIDTH-1-STEP:0], s_in_r};
      MODE_SHR:  q_next = {s_in_l, q[WIDTH-1:STEP]};
      MODE_ROL:  q_next = {q[WIDTH-1-STEP:0], q[WIDTH-1:WIDTH-STEP]};
      MODE_ROR:  q_next = {q[STEP-1:0], q[WIDTH-1:STEP]};
      MODE_LOAD: q_next = p_in;
      MODE_ASR:  q_next = {{STEP{q[WIDTH-1]}}, q[WIDTH-1:STEP]};
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a counted burst engine: one accepted start
// performs `count` shift operations, then pulses done for one cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; LOAD and count=0 requests finish here
// RUN     | one operation per cycle until the remaining count reaches 1
// DONE    | done pulse, all requests ignored, then back to IDLE
import shift_reg_pkg::*;

module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] p_in,
  input  logic [STEP-1:0]  s_in_l,
  input  logic [STEP-1:0]  s_in_r,
  output logic [WIDTH-1:0] q,
  output logic [STEP-1:0]  s_out_l,
  output logic [STEP-1:0]  s_out_r,
  output logic             busy,
  output logic             done
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] q_step;

  // Burst operations use the mode latched at start, never the live input.
  shift_reg_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .q      (q_q),
    .mode   (mode_q),
    .s_in_l (s_in_l),
    .s_in_r (s_in_r),
    .p_in   (p_in),
    .q_next (q_step)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    q_d     = q_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          if (mode == MODE_LOAD) begin
            q_d     = p_in;
            state_d = ST_DONE;
          end else if (count == '0) begin
            state_d = ST_DONE;
          end else begin
            rem_d   = count;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        q_d   = q_step;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= MODE_HOLD;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      q_q     <= q_d;
    end
  end

  assign q       = q_q;
  assign s_out_l = q_q[WIDTH-1 -: STEP];
  assign s_out_r = q_q[STEP-1:0];
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8, STEP=1, CNT_W=4): directed scenarios plus
// random bursts, checked against an arithmetic reference of the register.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [2:0] mode;
  logic [3:0] count;
  logic [7:0] p_in;
  logic [0:0] s_in_l;
  logic [0:0] s_in_r;
  logic [7:0] q;
  logic [0:0] s_out_l;
  logic [0:0] s_out_r;
  logic       busy;
  logic       done;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  logic [7:0] m_q      = 8'h00;

  univ_shift_reg #(
    .WIDTH (8),
    .STEP  (1),
    .CNT_W (4)
  ) dut (
    .clk     (clk),
    .clr     (clr),
    .start   (start),
    .mode    (mode),
    .count   (count),
    .p_in    (p_in),
    .s_in_l  (s_in_l),
    .s_in_r  (s_in_r),
    .q       (q),
    .s_out_l (s_out_l),
    .s_out_r (s_out_r),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Register value after one operation, computed as plain integer arithmetic.
  function automatic logic [7:0] ref_op(input logic [2:0] md, input logic [7:0] v,
                                        input logic sl, input logic sr);
    int x;
    int r;
    x = int'(v);
    case (md)
      3'd1:    r = (x * 2 + int'(sr)) % 256;
      3'd2:    r = x / 2 + int'(sl) * 128;
      3'd3:    r = (x * 2) % 256 + x / 128;
      3'd4:    r = x / 2 + (x % 2) * 128;
      3'd6:    r = x / 2 + (x / 128) * 128;
      default: r = x;
    endcase
    return 8'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic exp_busy, input logic exp_done);
    chk({tag, "_q"},     32'(q),       32'(m_q));
    chk({tag, "_busy"},  32'(busy),    32'(exp_busy));
    chk({tag, "_done"},  32'(done),    32'(exp_done));
    chk({tag, "_soutl"}, 32'(s_out_l), 32'(m_q[7]));
    chk({tag, "_soutr"}, 32'(s_out_r), 32'(m_q[0]));
  endtask

  // Issue one request at a negedge; sr_fix < 0 means random serial input.
  task automatic run_op(input string tag, input logic [2:0] md, input int n,
                        input logic [7:0] pin, input int sr_fix);
    logic sl;
    logic sr;
    start  = 1'b1;
    mode   = md;
    count  = 4'(n);
    p_in   = pin;
    s_in_l = 1'($urandom);
    s_in_r = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    if (md == 3'd5) m_q = pin;
    if (md == 3'd5 || n == 0) begin
      chk_state({tag, "_fin"}, 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < n; i++) begin
        chk_state({tag, "_run"}, 1'b1, 1'b0);
        sl     = 1'($urandom);
        sr     = (sr_fix < 0) ? 1'($urandom) : sr_fix[0];
        s_in_l = sl;
        s_in_r = sr;
        start  = 1'($urandom);
        mode   = 3'($urandom);
        count  = 4'($urandom);
        p_in   = 8'($urandom);
        @(negedge clk);
        m_q = ref_op(md, m_q, sl, sr);
      end
      chk_state({tag, "_fin"}, 1'b0, 1'b1);
    end
    start = 1'($urandom);
    mode  = 3'($urandom);
    count = 4'($urandom);
    p_in  = 8'($urandom);
    @(negedge clk);
    start = 1'b0;
    chk_state({tag, "_idle"}, 1'b0, 1'b0);
  endtask

  initial begin
    clr    = 1'b0;
    start  = 1'b0;
    mode   = 3'd0;
    count  = 4'd0;
    p_in   = 8'h00;
    s_in_l = 1'b0;
    s_in_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_state("reset", 1'b0, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    chk_state("release", 1'b0, 1'b0);
    @(negedge clk);
    chk_state("release2", 1'b0, 1'b0);

    run_op("load_a5", 3'd5, 3, 8'hA5, -1);
    chk("load_a5_val", 32'(q), 32'h0000_00A5);

    run_op("shl3", 3'd1, 3, 8'h00, 1);
    chk("shl3_val", 32'(q), 32'h0000_002F);

    run_op("load_90", 3'd5, 0, 8'h90, -1);
    run_op("asr2", 3'd6, 2, 8'h00, -1);
    chk("asr2_val", 32'(q), 32'h0000_00E4);

    run_op("load_a5b", 3'd5, 0, 8'hA5, -1);
    run_op("ror8", 3'd4, 8, 8'h00, -1);
    chk("ror8_val", 32'(q), 32'h0000_00A5);

    run_op("load_3c", 3'd5, 0, 8'h3C, -1);
    run_op("shl0", 3'd1, 0, 8'h00, -1);
    chk("shl0_val", 32'(q), 32'h0000_003C);

    run_op("max_rol", 3'd3, 15, 8'h00, -1);
    run_op("rsvd", 3'd7, 2, 8'h00, -1);

    // Reset dropped during the second busy cycle of a 5-op burst.
    run_op("load_5a", 3'd5, 0, 8'h5A, -1);
    start = 1'b1;
    mode  = 3'd1;
    count = 4'd5;
    @(negedge clk);
    start = 1'b0;
    chk_state("mid_c1", 1'b1, 1'b0);
    s_in_r = 1'b1;
    @(negedge clk);
    m_q = ref_op(3'd1, m_q, 1'b0, 1'b1);
    chk_state("mid_c2", 1'b1, 1'b0);
    #2 clr = 1'b0;
    #1;
    m_q = 8'h00;
    chk_state("mid_rst", 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk_state("mid_rel", 1'b0, 1'b0);
    run_op("load_11", 3'd5, 0, 8'h11, -1);
    chk("load_11_val", 32'(q), 32'h0000_0011);

    for (int k = 0; k < 40; k++) begin
      run_op("rnd", 3'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
             8'($urandom), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
